// File: rtl/hamming_tx_if.sv
// Byte-in / serial-out bundle for the Hamming(12,8) transmitter.
// The source drives the master side; the transmitter owns the slave side.
interface hamming_tx_if;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        inj_en;
  logic [3:0]  inj_pos;
  logic        tx;
  logic        busy;
  logic [11:0] code_out;
  logic        frame_done;

  modport master (
    output din, din_valid, inj_en, inj_pos,
    input  din_ready, tx, busy, code_out, frame_done
  );

  modport slave (
    input  din, din_valid, inj_en, inj_pos,
    output din_ready, tx, busy, code_out, frame_done
  );
endinterface

// File: rtl/hamming_tx.sv
// Hamming(12,8) SEC encoder with start/stop serialiser and single-bit error injection.
// Codeword layout matches the team's combinational Hamming(12,8) decoder.
module hamming_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input logic         clk,
  input logic         rst,
  hamming_tx_if.slave bus
);

  localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Check bits sit at the power-of-two positions (1-based) so the decoder's
  // syndrome directly names the flipped bit.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    bit_q, bit_d;
  logic [11:0]   shift_q, shift_d;
  logic [11:0]   code_q, code_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          din_ready_q, din_ready_d;
  logic          frame_done_q, frame_done_d;
  logic          accept;
  logic [11:0]   inj_mask;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    code_d   = code_q;
    inj_mask = '0;
    if (bus.inj_en && (bus.inj_pos < 4'd12)) begin
      inj_mask[bus.inj_pos] = 1'b1;
    end

    // din_ready_q is only ever high in IDLE, so accept implies IDLE.
    accept = bus.din_valid && din_ready_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          cyc_d   = '0;
          code_d  = encode(bus.din) ^ inj_mask;
          shift_d = code_d;
        end
      end
      START: begin
        if (cyc_q == CYC_LAST) begin
          state_d = DATA;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      STOP: begin
        if (cyc_q == CYC_LAST) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so they are registered yet
    // line up with the state they describe.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d       = (state_d != IDLE);
    din_ready_d  = (state_d == IDLE);
    frame_done_d = (state_d == STOP) && (cyc_d == CYC_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      code_q       <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      din_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      code_q       <= code_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      din_ready_q  <= din_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.din_ready  = din_ready_q;
  assign bus.code_out   = code_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hamming_tx.sv
// Directed bench for hamming_tx: encode table, injection, back-to-back timing,
// mid-frame reset, and a CLKS_PER_BIT=1 instance.
module tb_hamming_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 14 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_tx_if bus ();
  hamming_tx_if bus1 ();

  hamming_tx #(.CLKS_PER_BIT(CPB)) dut  (.clk(clk), .rst(rst), .bus(bus));
  hamming_tx #(.CLKS_PER_BIT(1))   dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Position-based reference decoder: XOR of 1-based positions of set bits.
  function automatic logic [11:0] decode(input logic [11:0] c);
    logic [3:0]  syn;
    logic [11:0] f;
    logic [7:0]  d;
    int          k;
    int          s;
    syn = '0;
    for (int p = 1; p <= 12; p++) if (c[p-1]) syn ^= 4'(p);
    f = c;
    s = int'(syn);
    if (s != 0 && s <= 12) f[s-1] = ~f[s-1];
    k = 0;
    d = '0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = f[p-1];
        k++;
      end
    end
    return {syn, d};
  endfunction

  int         cyc_n = 0;
  logic [7:0] acc_q[$];
  int         acc_cyc[$];

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!rst && bus.din_valid && bus.din_ready) begin
      acc_q.push_back(bus.din);
      acc_cyc.push_back(cyc_n);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Present a byte and return right after the accepting edge.
  task automatic offer(input logic [7:0] b, input logic en, input logic [3:0] pos, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    bus.din       = b;
    bus.din_valid = 1'b1;
    bus.inj_en    = en;
    bus.inj_pos   = pos;
    while (!bus.din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 32'(n < 200), 32'd1);
    @(posedge clk);
  endtask

  // Observe one full frame starting with the first cycle after the accept edge.
  task automatic run_frame(input logic [11:0] exp, input string tag, output logic [11:0] cap);
    int   slot, ph, bad_start, bad_stop, bad_hold, bad_ctl, fd_cnt;
    logic fd_last;
    bad_start = 0; bad_stop = 0; bad_hold = 0; bad_ctl = 0; fd_cnt = 0;
    fd_last = 1'b0;
    cap = '0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      slot = c / CPB;
      ph   = c % CPB;
      if (!bus.busy || bus.din_ready) bad_ctl++;
      if (bus.frame_done) fd_cnt++;
      if (c == FRAME - 1) fd_last = bus.frame_done;
      if (slot == 0) begin
        if (bus.tx !== 1'b0) bad_start++;
      end else if (slot == 13) begin
        if (bus.tx !== 1'b1) bad_stop++;
      end else if (ph == 0) begin
        cap[slot-1] = bus.tx;
      end else if (bus.tx !== cap[slot-1]) begin
        bad_hold++;
      end
    end
    check({tag, "_code_out"},  32'(bus.code_out), 32'(exp));
    check({tag, "_tx_bits"},   32'(cap), 32'(exp));
    check({tag, "_start_bad"}, 32'(bad_start), 32'd0);
    check({tag, "_stop_bad"},  32'(bad_stop), 32'd0);
    check({tag, "_bit_hold"},  32'(bad_hold), 32'd0);
    check({tag, "_busy_rdy"},  32'(bad_ctl), 32'd0);
    check({tag, "_fd_count"},  32'(fd_cnt), 32'd1);
    check({tag, "_fd_last"},   32'(fd_last), 32'd1);
    @(negedge clk);
    check({tag, "_idle_after"}, 32'({bus.tx, bus.busy, bus.din_ready, bus.frame_done}), 32'b1010);
  endtask

  logic [7:0]  vin  [4] = '{8'hFF, 8'h01, 8'h80, 8'hA5};
  logic [11:0] vexp [4] = '{12'hF77, 12'h007, 12'h888, 12'hA27};

  initial begin
    logic [11:0] cap;
    logic [11:0] dec;
    logic [11:0] cap1;
    int          n, bad1, fd1;
    logic        fd1_last;

    bus.din = '0;  bus.din_valid = 1'b0;  bus.inj_en = 1'b0;  bus.inj_pos = '0;
    bus1.din = '0; bus1.din_valid = 1'b0; bus1.inj_en = 1'b0; bus1.inj_pos = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx",         32'(bus.tx), 32'd1);
    check("rst_busy",       32'(bus.busy), 32'd0);
    check("rst_din_ready",  32'(bus.din_ready), 32'd0);
    check("rst_code_out",   32'(bus.code_out), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.din_ready), 32'd1);

    // All-zero byte
    offer(8'h00, 1'b0, 4'd0, "zero");
    #1 bus.din_valid = 1'b0;
    run_frame(12'h000, "zero", cap);

    // Encode table
    for (int i = 0; i < 4; i++) begin
      offer(vin[i], 1'b0, 4'd0, $sformatf("enc%0d", i));
      #1 bus.din_valid = 1'b0;
      run_frame(vexp[i], $sformatf("enc%0d", i), cap);
    end

    // Injection at bit 5; inj_pos change mid-frame must not matter
    offer(8'hA5, 1'b1, 4'd5, "inj");
    #1 bus.din_valid = 1'b0;
    bus.inj_pos = 4'd0;
    run_frame(12'hA07, "inj", cap);
    dec = decode(cap);
    check("inj_dec_data", 32'(dec[7:0]), 32'h A5);
    check("inj_dec_syn",  32'(dec[11:8]), 32'd6);

    // Out-of-range injection position is ignored
    offer(8'hA5, 1'b1, 4'd13, "inj_ign");
    #1 bus.din_valid = 1'b0;
    bus.inj_en = 1'b0;
    run_frame(12'hA27, "inj_ign", cap);

    // Back-to-back with din_valid held
    acc_q.delete();
    acc_cyc.delete();
    offer(8'h12, 1'b0, 4'd0, "b2b0");
    #1 bus.din = 8'h34;
    run_frame(12'h198, "b2b0", cap);
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
    run_frame(12'h329, "b2b1", cap);
    check("b2b_accepts", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      check("b2b_byte0",   32'(acc_q[0]), 32'h12);
      check("b2b_byte1",   32'(acc_q[1]), 32'h34);
      check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(FRAME + 1));
    end

    // Mid-frame reset during DATA bit 6
    offer(8'hA5, 1'b0, 4'd0, "mrst");
    #1 bus.din_valid = 1'b0;
    repeat (CPB + 6 * CPB + 2) @(negedge clk);
    check("mrst_pre_busy", 32'(bus.busy), 32'd1);
    check("mrst_pre_tx",   32'(bus.tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mrst_tx",       32'(bus.tx), 32'd1);
    check("mrst_busy",     32'(bus.busy), 32'd0);
    check("mrst_code_out", 32'(bus.code_out), 32'd0);
    check("mrst_ready",    32'(bus.din_ready), 32'd0);
    check("mrst_fd",       32'(bus.frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_rel_ready", 32'(bus.din_ready), 32'd1);
    offer(8'h5A, 1'b0, 4'd0, "after_rst");
    #1 bus.din_valid = 1'b0;
    run_frame(12'h550, "after_rst", cap);

    // CLKS_PER_BIT=1 instance
    n = 0;
    @(negedge clk);
    bus1.din = 8'h34;
    bus1.din_valid = 1'b1;
    while (!bus1.din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cpb1_ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 bus1.din_valid = 1'b0;
    bad1 = 0; fd1 = 0; cap1 = '0; fd1_last = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus1.frame_done) fd1++;
      if (!bus1.busy) bad1++;
      if (c == 0) begin
        if (bus1.tx !== 1'b0) bad1++;
      end else if (c == 13) begin
        if (bus1.tx !== 1'b1) bad1++;
        fd1_last = bus1.frame_done;
      end else begin
        cap1[c-1] = bus1.tx;
      end
    end
    check("cpb1_tx_bits",  32'(cap1), 32'h329);
    check("cpb1_code_out", 32'(bus1.code_out), 32'h329);
    check("cpb1_framing",  32'(bad1), 32'd0);
    check("cpb1_fd_count", 32'(fd1), 32'd1);
    check("cpb1_fd_last",  32'(fd1_last), 32'd1);
    @(negedge clk);
    check("cpb1_idle", 32'({bus1.tx, bus1.busy, bus1.din_ready}), 32'b101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
